// File: rtl/student_iis_pkg.sv
// Shared types for the I2S / left-justified DAC transmitter.
package student_iis_pkg;

    typedef enum logic {
        IIS_MODE_I2S = 1'b0,
        IIS_MODE_LJ  = 1'b1
    } iis_mode_e;

    localparam int IIS_SAMPLE_W = 16;

    typedef struct packed {
        logic signed [IIS_SAMPLE_W-1:0] l;
        logic signed [IIS_SAMPLE_W-1:0] r;
    } iis_pair_t;

endpackage

// File: rtl/student_sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop must be qualified by full/empty upstream.
module student_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               wdata_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("student_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [LVL_W-1:0] level_q;

    // NOTE: storage has no reset; the level counter alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            if (push_i && !pop_i)      level_q <= level_q + 1'b1;
            else if (pop_i && !push_i) level_q <= level_q - 1'b1;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/student_iis_transmitter_fifo.sv
// FIFO-buffered I2S/left-justified serialiser for the DAC path.
// Define STUDENT_IIS_TX_HOLD_LAST_EN to repeat the last popped pair on underrun instead of sending zeros.
module student_iis_transmitter_fifo
    import student_iis_pkg::*;
#(
    parameter int DATA_SIZE_FIR_OUT = 16,
    parameter int SLOT_WIDTH        = 24,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [DATA_SIZE_FIR_OUT-1:0]        data_l_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0]        data_r_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  iis_mode_e                           mode_i,
    input  logic                                lrclk_rise_i,
    input  logic                                lrclk_fall_i,
    input  logic                                bclk_fall_i,
    output logic                                sdata_o,
    output logic                                underrun_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_o
);

    localparam int PAIR_W = 2 * DATA_SIZE_FIR_OUT;
    localparam int SR_W   = SLOT_WIDTH + 1;

    if (DATA_SIZE_FIR_OUT < 1 || DATA_SIZE_FIR_OUT > SLOT_WIDTH) begin : g_width_check
        $error("student_iis_transmitter_fifo: need 1 <= DATA_SIZE_FIR_OUT <= SLOT_WIDTH");
    end

    typedef struct packed {
        logic [DATA_SIZE_FIR_OUT-1:0] l;
        logic [DATA_SIZE_FIR_OUT-1:0] r;
    } pair_t;

    // Sample is MSB-aligned in the slot; the spare bit is the I2S delay bit or the LJ tail.
    function automatic logic [SR_W-1:0] format_slot(input logic [DATA_SIZE_FIR_OUT-1:0] s,
                                                    input iis_mode_e m);
        logic [SLOT_WIDTH-1:0] slot;
        slot = '0;
        slot[SLOT_WIDTH-1 -: DATA_SIZE_FIR_OUT] = s;
        return (m == IIS_MODE_LJ) ? {slot, 1'b0} : {1'b0, slot};
    endfunction

    logic              fifo_full, fifo_empty, push, pop;
    logic [PAIR_W-1:0] fifo_rdata;
    pair_t             rd_pair, underrun_pair, frame_pair;

    logic [SR_W-1:0]              sr_q;
    logic [DATA_SIZE_FIR_OUT-1:0] hold_r_q;
    iis_mode_e                    mode_q;
    logic                         underrun_q;

    assign ready_o = !fifo_full;
    assign push    = valid_i && ready_o;
    assign pop     = lrclk_fall_i && !fifo_empty;
    assign rd_pair = fifo_rdata;

    student_sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({data_l_i, data_r_i}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

`ifdef STUDENT_IIS_TX_HOLD_LAST_EN
    pair_t last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  last_q <= '0;
        else if (pop) last_q <= rd_pair;
    end

    assign underrun_pair = last_q;
`else
    assign underrun_pair = '0;
`endif

    always_comb begin
        // NOTE: assign a default before any condition so no latch is inferred.
        frame_pair = underrun_pair;
        if (!fifo_empty) frame_pair = rd_pair;
    end

    // LRCLK strobes take priority over the BCLK shift; the new mode applies from this frame on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q       <= '0;
            hold_r_q   <= '0;
            mode_q     <= IIS_MODE_I2S;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (lrclk_fall_i) begin
                mode_q     <= mode_i;
                sr_q       <= format_slot(frame_pair.l, mode_i);
                hold_r_q   <= frame_pair.r;
                underrun_q <= fifo_empty;
            end else if (lrclk_rise_i) begin
                sr_q <= format_slot(hold_r_q, mode_q);
            end else if (bclk_fall_i) begin
                sr_q <= {sr_q[SR_W-2:0], 1'b0};
            end
        end
    end

    assign sdata_o    = sr_q[SR_W-1];
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_student_iis_transmitter_fifo.sv
// Randomised bench for student_iis_transmitter_fifo against a queue-and-bit-position model.
module tb_student_iis_transmitter_fifo;
    import student_iis_pkg::*;

    localparam int DW    = 16;
    localparam int SW    = 24;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);
    localparam int BCLKS_PER_HALF = SW + 2;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] data_l_i, data_r_i;
    logic          valid_i, ready_o;
    iis_mode_e     mode_i;
    logic          lrclk_rise_i, lrclk_fall_i, bclk_fall_i;
    logic          sdata_o, underrun_o;
    logic [LW-1:0] level_o;

    always #5 clk = ~clk;

    student_iis_transmitter_fifo #(
        .DATA_SIZE_FIR_OUT (DW),
        .SLOT_WIDTH        (SW),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .data_l_i     (data_l_i),
        .data_r_i     (data_r_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .mode_i       (mode_i),
        .lrclk_rise_i (lrclk_rise_i),
        .lrclk_fall_i (lrclk_fall_i),
        .bclk_fall_i  (bclk_fall_i),
        .sdata_o      (sdata_o),
        .underrun_o   (underrun_o),
        .level_o      (level_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: stored pairs, the sample being sent, and how many BCLKs into its slot we are.
    iis_pair_t     m_q[$];
    logic [DW-1:0] m_cur, m_hold_r;
    iis_mode_e     m_cur_mode, m_mode_lat;
    int            m_pos;
    iis_pair_t     m_last;
    logic          m_urun;

    task automatic model_reset();
        m_q.delete();
        m_cur      = '0;
        m_hold_r   = '0;
        m_cur_mode = IIS_MODE_I2S;
        m_mode_lat = IIS_MODE_I2S;
        m_pos      = 0;
        m_last     = '0;
        m_urun     = 1'b0;
    endtask

    function automatic logic exp_sdata();
        if (m_cur_mode == IIS_MODE_I2S) begin
            if (m_pos >= 1 && m_pos <= DW) return m_cur[DW - m_pos];
        end else begin
            if (m_pos < DW) return m_cur[DW - 1 - m_pos];
        end
        return 1'b0;
    endfunction

    task automatic step();
        bit        push_ok;
        iis_pair_t p;
        push_ok = valid_i && (m_q.size() < DEPTH);
        m_urun  = 1'b0;
        if (lrclk_fall_i) begin
            m_mode_lat = mode_i;
            if (m_q.size() > 0) begin
                p      = m_q.pop_front();
                m_last = p;
            end else begin
`ifdef STUDENT_IIS_TX_HOLD_LAST_EN
                p = m_last;
`else
                p = '0;
`endif
                m_urun = 1'b1;
            end
            m_cur      = p.l;
            m_hold_r   = p.r;
            m_cur_mode = mode_i;
            m_pos      = 0;
        end else if (lrclk_rise_i) begin
            m_cur      = m_hold_r;
            m_cur_mode = m_mode_lat;
            m_pos      = 0;
        end else if (bclk_fall_i) begin
            m_pos++;
        end
        if (push_ok) begin
            p.l = data_l_i;
            p.r = data_r_i;
            m_q.push_back(p);
        end
        @(posedge clk);
        #1;
        check("sdata",    {31'b0, sdata_o},    {31'b0, exp_sdata()});
        check("underrun", {31'b0, underrun_o}, {31'b0, m_urun});
        check("level",    {{(32-LW){1'b0}}, level_o}, m_q.size());
        check("ready",    {31'b0, ready_o},    (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
    endtask

    task automatic rand_valid(input int pct);
        valid_i  = ($urandom_range(0, 99) < pct);
        data_l_i = DW'($urandom);
        data_r_i = DW'($urandom);
    endtask

    task automatic run_half(input bit left, input int pct, input bit rnd_mode, input int n_bclk);
        lrclk_fall_i = left;
        lrclk_rise_i = !left;
        bclk_fall_i  = 1'($urandom_range(0, 1));
        rand_valid(pct);
        step();
        lrclk_fall_i = 1'b0;
        lrclk_rise_i = 1'b0;
        for (int b = 0; b < n_bclk; b++) begin
            for (int k = 0; k < 4; k++) begin
                bclk_fall_i = (k == 3);
                rand_valid(pct);
                if (rnd_mode && $urandom_range(0, 99) < 3)
                    mode_i = (mode_i == IIS_MODE_I2S) ? IIS_MODE_LJ : IIS_MODE_I2S;
                step();
            end
        end
        bclk_fall_i = 1'b0;
        valid_i     = 1'b0;
    endtask

    task automatic run_frame(input int pct, input bit rnd_mode);
        run_half(1'b1, pct, rnd_mode, BCLKS_PER_HALF);
        run_half(1'b0, pct, rnd_mode, BCLKS_PER_HALF);
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        valid_i  = 1'b1;
        data_l_i = l;
        data_r_i = r;
        step();
        valid_i  = 1'b0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        data_l_i     = '0;
        data_r_i     = '0;
        valid_i      = 1'b0;
        mode_i       = IIS_MODE_I2S;
        lrclk_rise_i = 1'b0;
        lrclk_fall_i = 1'b0;
        bclk_fall_i  = 1'b0;
        model_reset();

        #3;
        check("rst_sdata",    {31'b0, sdata_o},    32'd0);
        check("rst_level",    {{(32-LW){1'b0}}, level_o}, 32'd0);
        check("rst_ready",    {31'b0, ready_o},    32'd1);
        check("rst_underrun", {31'b0, underrun_o}, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Known pair, I2S then left-justified
        push_pair(16'h8001, 16'h7FFE);
        run_frame(0, 1'b0);
        mode_i = IIS_MODE_LJ;
        push_pair(16'h8001, 16'h7FFE);
        run_frame(0, 1'b0);
        mode_i = IIS_MODE_I2S;

        // Fill past capacity, then drain until an underrun frame
        for (int i = 0; i < DEPTH + 1; i++) begin
            rand_valid(100);
            step();
        end
        valid_i = 1'b0;
        check("full_level", {{(32-LW){1'b0}}, level_o}, DEPTH);
        check("full_ready", {31'b0, ready_o}, 32'd0);
        for (int f = 0; f < DEPTH + 1; f++) run_frame(0, 1'b0);

        // Mode changes at random points inside frames
        for (int f = 0; f < 6; f++) run_frame(30, 1'b1);

        // Asynchronous reset in the middle of a slot
        mode_i = IIS_MODE_I2S;
        push_pair(16'hFFFF, 16'hFFFF);
        push_pair(16'h1234, 16'h5678);
        run_half(1'b1, 0, 1'b0, 6);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check("arst_sdata",    {31'b0, sdata_o},    32'd0);
        check("arst_level",    {{(32-LW){1'b0}}, level_o}, 32'd0);
        check("arst_ready",    {31'b0, ready_o},    32'd1);
        check("arst_underrun", {31'b0, underrun_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        run_frame(0, 1'b0);

        // Fully random traffic
        for (int f = 0; f < 20; f++) run_frame($urandom_range(5, 90), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
